// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state type and lane adder for acc_array
// Lane adder clamps or wraps on overflow depending on the caller's sat input.
package acc_pkg;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_t;

  // Wide enough for any ACC_W up to 64 plus the overflow guard bit
  localparam int SUM_W = 65;

  typedef struct packed {
    logic [SUM_W-1:0] val;
    logic             ovf;
  } add_res_t;

  // a and b arrive sign-extended to SUM_W; w is the accumulator width
  function automatic add_res_t sat_add(input logic [SUM_W-1:0] a,
                                       input logic [SUM_W-1:0] b,
                                       input logic [6:0]       w,
                                       input logic             sat);
    add_res_t         r;
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] lim;
    s   = a + b;
    lim = {SUM_W{1'b1}} << (w - 7'd1);
    if (!s[w]) lim = ~lim;
    r.ovf = s[w] ^ s[w - 7'd1];
    r.val = (sat && r.ovf) ? lim : s;
    return r;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// rtl/acc_lane.sv - one signed accumulation lane with sticky overflow flag
// ACC_SAT_EN defined: clamp on overflow; undefined: wrap modulo 2^ACC_W.
module acc_lane
  import acc_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

`ifdef ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  add_res_t               res;
  logic [ACC_W-1:0]       sum_lo;
  logic [SUM_W-ACC_W-1:0] sum_hi_unused;

  always_comb begin
    res = sat_add(SUM_W'($signed(acc_q)), SUM_W'($signed(din)), 7'(ACC_W), SAT_EN);
    {sum_hi_unused, sum_lo} = res.val;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      acc_d = sum_lo;
      ovf_d = ovf_q | res.ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/acc_array.sv
// rtl/acc_array.sv - multi-lane streaming accumulator with result handshake
// Lane overflow behaviour selected by ACC_SAT_EN (see acc_lane).
module acc_array
  import acc_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]     out_count,
  output logic [NCH-1:0]       out_ovf
);

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             drain;
  logic             lane_clr;

  always_comb begin
    // rst_n gates ready so nothing looks acceptable while reset is held
    in_ready  = rst_n && (state_q != HOLD) && !clear;
    accept    = in_valid && in_ready;
    drain     = (state_q == HOLD) && out_ready;
    lane_clr  = clear || drain;
    out_valid = (state_q == HOLD);
    out_count = cnt_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (lane_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = in_last ? HOLD : ACC;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lane_clr),
      .en    (accept),
      .din   (in_data[g*IN_W +: IN_W]),
      .acc   (out_data[g*ACC_W +: ACC_W]),
      .ovf   (out_ovf[g])
    );
  end

endmodule
